// File: rtl/exmem_dmem_ctrl.sv
// Data-memory access sequencer for the EX/MEM stage: req/ack handshake, pipeline stall,
// load-data capture and bus-error reporting (misalignment, illegal op, timeout).
module exmem_dmem_ctrl #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic op, illegal;

    assign op      = mem_read_i | mem_write_i;
    assign illegal = (mem_read_i & mem_write_i) | (op & (addr_i[1:0] != 2'b00));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        stall_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (op) begin
                    stall_o = 1'b1;
                    if (illegal) begin
                        // Rejected without ever touching the bus.
                        state_d = StDone;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = StBusy;
                        req_d   = 1'b1;
                        we_d    = mem_write_i;
                        addr_d  = {addr_i[31:2], 2'b00};
                        wdata_d = wdata_i;
                        cnt_d   = '0;
                    end
                end
            end
            StBusy: begin
                stall_o = 1'b1;
                // An ack coinciding with the last timeout cycle still completes the access.
                if (mem_ack_i) begin
                    state_d = StDone;
                    req_d   = 1'b0;
                    err_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = mem_rdata_i;
                    end
                end else if (cnt_q == CntLast) begin
                    state_d = StDone;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                // Stall drops here so the held op advances; it is not re-evaluated.
                state_d = StIdle;
                err_d   = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    assign bus_err_o   = err_q;

endmodule

// File: doc/exmem_dmem_ctrl.md
Name: exmem_dmem_ctrl

Overview:
- Sequences data-memory accesses issued from the EX/MEM pipeline register towards a variable-latency data memory using a req/ack handshake.
- Generates the global pipeline stall that holds PC, IF/ID, ID/EX and EX/MEM while an access is outstanding.
- Captures load data for the MEM/WB stage.
- Flags misaligned or illegal accesses and memory timeouts as bus errors, without issuing a request for illegal accesses.

Parameters:
- TIMEOUT, 15: maximum cycles in BUSY waiting for mem_ack_i before the access is aborted; must be ≥1.
- CNT_W, 4: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- mem_read_i  input  1  OCMemRead from EX/MEM.
- mem_write_i  input  1  OCMemWrite from EX/MEM.
- addr_i  input  32  OALUResult from EX/MEM (byte address).
- wdata_i  input  32  OMemWrData from EX/MEM.
- mem_req_o  output  1  request to data memory, held until ack.
- mem_we_o  output  1  1 = write, 0 = read; valid while mem_req_o.
- mem_addr_o  output  32  word-aligned address; valid while mem_req_o.
- mem_wdata_o  output  32  write data; valid while mem_req_o.
- mem_ack_i  input  1  single-cycle completion from memory.
- mem_rdata_i  input  32  read data; valid with mem_ack_i on reads.
- stall_o  output  1  combinational; holds all upstream pipeline registers.
- rdata_o  output  32  registered load data for MEM/WB.
- bus_err_o  output  1  registered error flag, high only in DONE.

Behaviour:
- Reset values: state IDLE; mem_req_o=0; mem_we_o=0; mem_addr_o=0; mem_wdata_o=0; rdata_o=0; bus_err_o=0; timeout counter=0. Reset mid-access aborts immediately; no ack is awaited after reset.
- States are IDLE, BUSY and DONE.
- Access classification in IDLE:
  - op = mem_read_i | mem_write_i.
  - illegal = (mem_read_i & mem_write_i) | (op & addr_i[1:0] != 0).
- IDLE transitions:
  - op & !illegal: stall_o=1. Next edge: BUSY; mem_req_o←1; mem_we_o←mem_write_i; mem_addr_o←{addr_i[31:2],2'b00}; mem_wdata_o←wdata_i; counter←0.
  - op & illegal: stall_o=1. Next edge: DONE; bus_err_o←1; rdata_o←0; no request is issued.
  - !op: stall_o=0; remain in IDLE.
- BUSY: stall_o=1; mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o stay stable.
  - mem_ack_i sampled high: next edge DONE; mem_req_o←0; bus_err_o←0. For reads, rdata_o←mem_rdata_i. For writes, rdata_o holds its previous value.
  - No ack and counter == TIMEOUT-1: next edge DONE; mem_req_o←0; bus_err_o←1; rdata_o←0.
  - Otherwise: counter increments.
- DONE: stall_o=0, so the held EX/MEM contents advance to MEM/WB on this edge together with rdata_o/bus_err_o. Next edge: IDLE; bus_err_o←0.
- DONE must not re-issue the same op, even though mem_read_i/mem_write_i are still high in that cycle. The op is consumed.
- Latency: minimum 2 stall cycles (IDLE detect, BUSY with same-cycle ack), then 1 DONE cycle. A load with ack N cycles after mem_req_o rises stalls N+2 cycles.
- Back-to-back accesses: after DONE→IDLE, the next EX/MEM op is evaluated in IDLE in the following cycle; there are no bubbles beyond DONE.
- An ack arriving in IDLE or DONE (spurious) is ignored and has no state effect.
- An ack in the same cycle the timeout fires: the ack wins and the access is treated as completed, with no error.
- mem_ack_i, mem_rdata_i and all EX/MEM inputs are sampled only in the states listed above.

Test Plan:
- Reset then load: mem_read_i=1, addr_i=0x100, ack 3 cycles after req with rdata 0x12345678 → mem_addr_o=0x100, mem_we_o=0, stall_o high for 5 cycles, DONE shows rdata_o=0x12345678, bus_err_o=0, exactly one request.
- Store with same-cycle ack: mem_write_i=1, addr_i=0x204, wdata_i=0xCAFEBABE, ack in first BUSY cycle → mem_we_o=1, mem_wdata_o=0xCAFEBABE, stall 2 cycles, then DONE.
- Misaligned load addr_i=0x103, and separately read&write both high → no mem_req_o, DONE with bus_err_o=1, rdata_o=0, 1 stall cycle.
- Timeout: read with no ack, TIMEOUT=15 → mem_req_o high exactly 15 cycles, then DONE with bus_err_o=1, rdata_o=0. Ack on the 15th BUSY cycle instead → no error, data captured.
- Back-to-back load,store,load with ack latency 1 → three distinct requests, correct addresses/we in order; DONE is never followed by a duplicate request; spurious ack in IDLE is ignored.
- Async reset asserted mid-BUSY → mem_req_o, stall_o and state cleared immediately. A late ack after reset is ignored, and the next op starts cleanly.
